// File: rtl/ntt8_stage_ctrl.sv
// Load/compute/stream sequencer around an external 8-point butterfly unit.
// Optional NTT8_INPUT_REDUCE_EN: fold inputs in [q, 2^BIT_LEN) down by one q on load.
module ntt8_stage_ctrl #(
    parameter int BIT_LEN = 13,
    parameter int q       = 7681,
    parameter int BT_LAT  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BIT_LEN-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BIT_LEN-1:0] out_data,
    output logic               out_last,
    output logic               busy,
    output logic [BIT_LEN-1:0] bt_in0,
    output logic [BIT_LEN-1:0] bt_in1,
    output logic [BIT_LEN-1:0] bt_phi,
    input  logic [BIT_LEN-1:0] bt_out0,
    input  logic [BIT_LEN-1:0] bt_out1
);

    typedef enum logic [1:0] {LOAD, COMP, OUT} state_t;

    localparam int STAGE_CYC = 4 + BT_LAT;

    // The twiddle table below holds powers of w=1925 mod 7681 only.
    if (q != 7681 || BT_LAT < 1 || BT_LAT > 4) begin : g_bad_cfg
        $error("ntt8_stage_ctrl: unsupported q or BT_LAT");
    end

    state_t             state, state_nx;
    logic [BIT_LEN-1:0] coef [8];
    logic [2:0]         ld_cnt;
    logic [2:0]         out_cnt;
    logic [1:0]         stg;
    logic [2:0]         cyc;
    logic [BIT_LEN-1:0] in_val;

    logic               issue;
    logic [2:0]         a_addr, b_addr;
    logic [1:0]         tw_idx;
    logic [BIT_LEN-1:0] tw_val;

    logic [BT_LAT-1:0]  wv_d;
    logic [2:0]         wa_d [BT_LAT];
    logic [2:0]         wb_d [BT_LAT];

    function automatic logic [2:0] bitrev3(input logic [2:0] j);
        return {j[0], j[1], j[2]};
    endfunction

`ifdef NTT8_INPUT_REDUCE_EN
    always_comb begin
        in_val = in_data;
        if (in_data >= BIT_LEN'(q))
            in_val = in_data - BIT_LEN'(q);
    end
`else
    always_comb begin
        in_val = in_data;
    end
`endif

    // Pair p of a stage: k = p mod len, start = (p / len) * 2len, twiddle index k*4/len.
    always_comb begin
        a_addr = '0;
        b_addr = '0;
        tw_idx = '0;
        case (stg)
            2'd0: begin
                a_addr = {cyc[1:0], 1'b0};
                b_addr = a_addr + 3'd1;
                tw_idx = 2'd0;
            end
            2'd1: begin
                a_addr = {cyc[1], 1'b0, cyc[0]};
                b_addr = a_addr + 3'd2;
                tw_idx = {cyc[0], 1'b0};
            end
            default: begin
                a_addr = {1'b0, cyc[1:0]};
                b_addr = a_addr + 3'd4;
                tw_idx = cyc[1:0];
            end
        endcase
    end

    always_comb begin
        tw_val = '0;
        case (tw_idx)
            2'd0:    tw_val = BIT_LEN'(1);
            2'd1:    tw_val = BIT_LEN'(1925);
            2'd2:    tw_val = BIT_LEN'(3383);
            default: tw_val = BIT_LEN'(6468);
        endcase
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        busy      = 1'b0;
        issue     = 1'b0;
        bt_in0    = '0;
        bt_in1    = '0;
        bt_phi    = '0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && ld_cnt == 3'd7)
                    state_nx = COMP;
            end
            COMP: begin
                busy = 1'b1;
                if (cyc < 3'd4) begin
                    issue  = 1'b1;
                    bt_in0 = coef[a_addr];
                    bt_in1 = coef[b_addr];
                    bt_phi = tw_val;
                end
                if (stg == 2'd2 && cyc == 3'(STAGE_CYC - 1))
                    state_nx = OUT;
            end
            OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = coef[out_cnt];
                out_last  = (out_cnt == 3'd7);
                if (out_ready && out_cnt == 3'd7)
                    state_nx = LOAD;
            end
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= LOAD;
            ld_cnt  <= '0;
            out_cnt <= '0;
            stg     <= '0;
            cyc     <= '0;
            wv_d    <= '0;
            for (int unsigned i = 0; i < 8; i++)
                coef[i] <= '0;
            for (int unsigned i = 0; i < BT_LAT; i++) begin
                wa_d[i] <= '0;
                wb_d[i] <= '0;
            end
        end else begin
            state <= state_nx;

            if (state == LOAD && in_valid) begin
                coef[bitrev3(ld_cnt)] <= in_val;
                ld_cnt                <= ld_cnt + 3'd1;
            end

            if (state == COMP) begin
                if (cyc == 3'(STAGE_CYC - 1)) begin
                    cyc <= '0;
                    stg <= (stg == 2'd2) ? 2'd0 : stg + 2'd1;
                end else begin
                    cyc <= cyc + 3'd1;
                end
            end

            // Destination addresses ride alongside the BT pipeline.
            wv_d[0] <= issue;
            wa_d[0] <= a_addr;
            wb_d[0] <= b_addr;
            for (int unsigned i = 1; i < BT_LAT; i++) begin
                wv_d[i] <= wv_d[i-1];
                wa_d[i] <= wa_d[i-1];
                wb_d[i] <= wb_d[i-1];
            end
            if (wv_d[BT_LAT-1]) begin
                coef[wa_d[BT_LAT-1]] <= bt_out0;
                coef[wb_d[BT_LAT-1]] <= bt_out1;
            end

            if (state == OUT && out_ready)
                out_cnt <= out_cnt + 3'd1;
        end
    end

endmodule

// File: tb/tb_ntt8_stage_ctrl.sv
// Bench for ntt8_stage_ctrl: models the external butterfly unit and checks
// table vectors, corner sequences and random frames against a direct 8-point NTT sum.
module tb_ntt8_stage_ctrl;

    localparam int BL       = 13;
    localparam int Q        = 7681;
    localparam int LAT      = 1;
    localparam int COMP_CYC = 3 * (4 + LAT);

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [BL-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [BL-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic [BL-1:0] bt_in0, bt_in1, bt_phi;
    logic [BL-1:0] bt_out0, bt_out1;

    always #5 clk = ~clk;

    ntt8_stage_ctrl #(.BIT_LEN(BL), .q(Q), .BT_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy),
        .bt_in0(bt_in0), .bt_in1(bt_in1), .bt_phi(bt_phi),
        .bt_out0(bt_out0), .bt_out1(bt_out1)
    );

    // External butterfly: one register stage of modular arithmetic.
    always_ff @(posedge clk) begin
        bt_out0 <= BL'((longint'(bt_in0) + longint'(bt_in1) * longint'(bt_phi)) % Q);
        bt_out1 <= BL'((longint'(bt_in0) + Q - (longint'(bt_in1) * longint'(bt_phi)) % Q) % Q);
    end

    int checks = 0;
    int errors = 0;
    int comp_phi[$];
    int comp_ops[$];

    typedef struct {
        int x[8];
        int exp[8];
        int stall;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic void ref_ntt(input int x[8], output int xf[8]);
        longint wp[8];
        longint acc;
        wp[0] = 1;
        for (int i = 1; i < 8; i++) wp[i] = (wp[i-1] * 1925) % Q;
        for (int k = 0; k < 8; k++) begin
            acc = 0;
            for (int j = 0; j < 8; j++)
                acc = (acc + (longint'(x[j]) % Q) * wp[(j * k) % 8]) % Q;
            xf[k] = int'(acc);
        end
    endfunction

    task automatic send_frame(input int x[8], input bit gaps);
        int  j = 0;
        int  guard = 0;
        bit  acc;
        while (j < 8 && guard < 200) begin
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = in_valid ? BL'(x[j]) : BL'($urandom_range(0, 8191));
            acc      = in_valid && in_ready;
            @(negedge clk);
            if (acc) j++;
            guard++;
        end
        in_valid = 1'b0;
        in_data  = '0;
        if (j < 8) chk("load_timeout", j, 8);
    endtask

    task automatic recv_frame(input int exp[8], input int mode, output int busy_cnt);
        int k = 0, n = 0, guard = 0;
        bit rdy, prev_stall = 0;
        int prev_data = 0;
        busy_cnt = 0;
        comp_phi.delete();
        comp_ops.delete();
        while (k < 8 && guard < 400) begin
            if (busy) busy_cnt++;
            chk("in_ready_while_busy", int'(in_ready), 0);
            if (!out_valid) begin
                comp_phi.push_back(int'(bt_phi));
                comp_ops.push_back(int'(bt_in0 | bt_in1));
            end else begin
                chk($sformatf("out_data[%0d]", k), int'(out_data), exp[k]);
                chk($sformatf("out_last[%0d]", k), int'(out_last), int'(k == 7));
                if (prev_stall) chk("stall_stable", int'(out_data), prev_data);
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (n % 4 == 0) || (n % 4 == 3);
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            if (out_valid) n++;
            out_ready  = rdy;
            prev_stall = out_valid && !rdy;
            prev_data  = int'(out_data);
            if (out_valid && rdy) k++;
            @(negedge clk);
            guard++;
        end
        if (k < 8) chk("out_timeout", k, 8);
        chk("post_frame_busy", int'(busy), 0);
        chk("post_frame_out_valid", int'(out_valid), 0);
        chk("post_frame_in_ready", int'(in_ready), 1);
    endtask

    initial begin
        vec_t tbl[4];
        int   phitab[3][4];
        int   xr[8], er[8], bc, s, cc, e;

        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_bt", int'(bt_in0 | bt_in1 | bt_phi), 0);
        reset = 1'b0;

        tbl[0].x = '{5, 0, 0, 0, 0, 0, 0, 0};
        tbl[0].exp = '{5, 5, 5, 5, 5, 5, 5, 5};
        tbl[0].stall = 0;
        tbl[1].x = '{0, 1, 0, 0, 0, 0, 0, 0};
        tbl[1].exp = '{1, 1925, 3383, 6468, 7680, 5756, 4298, 1213};
        tbl[1].stall = 0;
        tbl[2].x = '{1, 1, 1, 1, 1, 1, 1, 1};
        tbl[2].exp = '{8, 0, 0, 0, 0, 0, 0, 0};
        tbl[2].stall = 0;
        tbl[3].x = '{0, 1, 0, 0, 0, 0, 0, 0};
        tbl[3].exp = '{1, 1925, 3383, 6468, 7680, 5756, 4298, 1213};
        tbl[3].stall = 1;
        phitab = '{'{1, 1, 1, 1}, '{1, 3383, 1, 3383}, '{1, 1925, 3383, 6468}};

        for (int i = 0; i < 4; i++) begin
            send_frame(tbl[i].x, 1'b0);
            recv_frame(tbl[i].exp, tbl[i].stall, bc);
            if (tbl[i].stall == 0) chk($sformatf("busy_cycles[%0d]", i), bc, COMP_CYC + 8);
            if (i == 2) begin
                chk("comp_len", comp_phi.size(), COMP_CYC);
                for (int c = 0; c < COMP_CYC && c < comp_phi.size(); c++) begin
                    s  = c / (4 + LAT);
                    cc = c % (4 + LAT);
                    e  = (cc < 4) ? phitab[s][cc] : 0;
                    chk($sformatf("bt_phi[c%0d]", c), comp_phi[c], e);
                    if (cc >= 4) chk($sformatf("bt_ops_idle[c%0d]", c), comp_ops[c], 0);
                end
            end
        end

        // Reset in the middle of the compute phase.
        xr = '{1, 1, 1, 1, 1, 1, 1, 1};
        send_frame(xr, 1'b0);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_bt", int'(bt_in0 | bt_in1 | bt_phi), 0);
        xr = '{9, 0, 0, 0, 0, 0, 0, 0};
        er = '{9, 9, 9, 9, 9, 9, 9, 9};
        send_frame(xr, 1'b0);
        recv_frame(er, 0, bc);

        for (int f = 0; f < 12; f++) begin
            for (int j = 0; j < 8; j++) xr[j] = int'($urandom_range(0, Q - 1));
            ref_ntt(xr, er);
            send_frame(xr, 1'b1);
            recv_frame(er, 2, bc);
        end

`ifdef NTT8_INPUT_REDUCE_EN
        xr = '{Q + 5, 0, 0, 0, 0, 0, 0, 0};
        er = '{5, 5, 5, 5, 5, 5, 5, 5};
        send_frame(xr, 1'b0);
        recv_frame(er, 0, bc);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ntt8_stage_ctrl.md
Name: ntt8_stage_ctrl

Overview:
- Sequencing and buffering stage wrapped around the 8-point butterfly unit (BT).
- Collects 8 coefficients from an upstream stream into a register buffer.
- Drives BT with operand pairs and twiddles for 3 Cooley-Tukey stages, writes BT results back, then streams the 8 NTT outputs downstream.
- BT is instantiated outside this block and connected through the bt_* ports.

Parameters:
BIT_LEN, 13, coefficient width
q, 7681, modulus
BT_LAT, 1, BT output latency in cycles (legal 1..4); BT as built is 1

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  upstream coefficient valid
in_ready  out  1  block accepts coefficient
in_data  in  BIT_LEN  coefficient x_j, natural order j=0..7
out_valid  out  1  output coefficient valid
out_ready  in  1  downstream accepts
out_data  out  BIT_LEN  X_k, natural order k=0..7
out_last  out  1  high with X_7
busy  out  1  high in COMP or OUT
bt_in0  out  BIT_LEN  butterfly operand a
bt_in1  out  BIT_LEN  butterfly operand b
bt_phi  out  BIT_LEN  twiddle
bt_out0  in  BIT_LEN  a+b*phi mod q, BT_LAT cycles after issue
bt_out1  in  BIT_LEN  a-b*phi mod q, BT_LAT cycles after issue

Behaviour:
- Transform: X_k = sum over j of x_j*w^(jk) mod q, with w=1925 (order 8). w^2=3383, w^3=6468, w^4=7680.
- Reset (synchronous, any state, including mid-LOAD/COMP/OUT):
  - state=LOAD; all counters 0; buffer cleared to 0.
  - in_ready=1; out_valid=0; out_last=0; out_data=0; busy=0; bt_in0/bt_in1/bt_phi=0.
- FSM LOAD -> COMP -> OUT -> LOAD.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready, store in_data at buf[bitrev3(j)], j=load count, and increment the count.
  - After the 8th accept, go to COMP on the next cycle; in_ready drops in that same next cycle.
- COMP:
  - Stages s=0,1,2 with len=1,2,4. Each stage = 4 issue cycles + BT_LAT drain cycles.
  - Issue order: for start=0,2len,... then k=0..len-1: a=buf[start+k], b=buf[start+k+len].
  - phi: w^(k*4/len). s0 all 1; s1 {1,3383}; s2 {1,1925,3383,6468}.
  - Operands are presented combinationally from the buffer during the issue cycle.
  - Destination addresses are delayed BT_LAT cycles, then bt_out0 -> buf[start+k] and bt_out1 -> buf[start+k+len].
  - The next stage's first issue happens only after the last writeback of the current stage.
  - bt_* outputs = 0 in non-issue cycles.
  - COMP length = 3*(4+BT_LAT) cycles (15 for BT_LAT=1).
- OUT:
  - out_valid=1; out_data=buf[k].
  - k advances on out_valid&&out_ready; out_last=1 when k=7.
  - Backpressure holds out_data stable.
  - After the X_7 handshake go to LOAD next cycle; a new frame is accepted from that cycle.
- Arithmetic: all modular work is done in BT; this block only moves data, generates addresses, and looks up twiddles (constant table).
- Input values >= q are undefined unless NTT8_INPUT_REDUCE_EN is set.
- End-to-end latency for BT_LAT=1 with no stalls: 8 load + 15 comp + 8 out cycles.

Optional Feature:
- Macro: NTT8_INPUT_REDUCE_EN.
- Defined: each accepted in_data >= q is stored as in_data-q; a single subtraction suffices because 2^13-1 < 2q. Values < q are stored unchanged.
- Undefined: in_data is stored raw.

Test Plan:
- Load x=[5,0,0,0,0,0,0,0], out_ready=1 -> X=[5,5,5,5,5,5,5,5]; out_last only on 8th; busy high 23 cycles.
- Load x=[0,1,0,0,0,0,0,0] -> X=[1,1925,3383,6468,7680,5756,4298,1213].
- Load x=[1,1,1,1,1,1,1,1] -> X=[8,0,0,0,0,0,0,0]; check BT issue sequence: s0 phi all 1, s1 phi 1,3383,1,3383, s2 phi 1,1925,3383,6468.
- Toggle out_ready 1,0,0,1 repeatedly with x1=1 frame -> same X sequence; out_data stable while stalled; in_ready=0 until after X_7 accept.
- Assert reset at COMP cycle 7 -> next cycle in_ready=1, busy=0, out_valid=0, bt_* = 0. Then a delta frame [9,0,...] -> all 9.
- With NTT8_INPUT_REDUCE_EN, load x0=7686 (q+5), others 0 -> X all 5. Without the macro this case is excluded.
